// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with boot/run/trap sequencing and retire counter
// Misaligned targets are never loaded; they latch into trap_pc and park the unit until reset.
module pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  pcsrc,
   input  logic [31:0] imm,
   input  logic [31:0] alu_result,
   input  logic        stall,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        valid,
   output logic [63:0] instret,
   output logic        trap,
   output logic [31:0] trap_pc
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] trap_pc_q, trap_pc_d;
   logic [63:0] instret_q, instret_d;
   logic        trap_q, trap_d;
   logic        retire;
   logic [31:0] target;

   assign pc_plus4 = pc_q + 32'd4;
   assign pc       = pc_q;
   assign instret  = instret_q;
   assign trap     = trap_q;
   assign trap_pc  = trap_pc_q;
   assign valid    = retire & ~rst;

   always_comb begin
      target = pc_q;
      case (pcsrc)
         2'b00:   target = pc_plus4;
         2'b01:   target = alu_result & ~32'd1;
         2'b10:   target = pc_q + imm;
         default: target = pc_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      trap_pc_d = trap_pc_q;
      instret_d = instret_q;
      trap_d    = trap_q;
      retire    = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            retire = ~stall;
            if (retire) begin
               // The trapping instruction itself still counts as retired.
               instret_d = instret_q + 64'd1;
               if (target[1:0] != 2'b00) begin
                  trap_d    = 1'b1;
                  trap_pc_d = target;
                  state_d   = TRAP;
               end else begin
                  pc_d = target;
               end
            end
         end
         TRAP:    state_d = TRAP;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         trap_pc_q <= 32'd0;
         instret_q <= 64'd0;
         trap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         trap_pc_q <= trap_pc_d;
         instret_q <= instret_d;
         trap_q    <= trap_d;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit
// Directed steps; expected post-edge state is queued at drive time and popped after the edge.
module tb_pc_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  pcsrc = 2'b00;
   logic [31:0] imm = 32'd0;
   logic [31:0] alu_result = 32'd0;
   logic        stall = 1'b0;
   logic [31:0] pc, pc_plus4, trap_pc;
   logic        valid, trap;
   logic [63:0] instret;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [63:0] instret;
      logic        trap;
      logic [31:0] trap_pc;
   } exp_t;

   exp_t sb[$];

   // reference state: 0 boot, 1 run, 2 trap
   int          m_state = 0;
   logic [31:0] m_pc = RST_PC;
   logic [63:0] m_instret = 64'd0;
   logic        m_trap = 1'b0;
   logic [31:0] m_trap_pc = 32'd0;

   pc_unit #(.RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .rst        (rst),
      .pcsrc      (pcsrc),
      .imm        (imm),
      .alu_result (alu_result),
      .stall      (stall),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .valid      (valid),
      .instret    (instret),
      .trap       (trap),
      .trap_pc    (trap_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] ps, input logic [31:0] im,
                       input logic [31:0] alu, input logic st);
      logic        exp_valid;
      logic [31:0] t;
      exp_t        e;
      exp_t        got;
      @(negedge clk);
      rst = r; pcsrc = ps; imm = im; alu_result = alu; stall = st;
      #1;
      exp_valid = !r && (m_state == 1) && !st;
      chk("valid", {63'd0, valid}, {63'd0, exp_valid});
      chk("pc_plus4", {32'd0, pc_plus4}, {32'd0, m_pc + 32'd4});
      if (r) begin
         m_state = 0; m_pc = RST_PC; m_instret = 64'd0; m_trap = 1'b0; m_trap_pc = 32'd0;
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1 && !st) begin
         if (ps == 2'b00)      t = m_pc + 32'd4;
         else if (ps == 2'b01) t = {alu[31:1], 1'b0};
         else if (ps == 2'b10) t = m_pc + im;
         else                  t = m_pc;
         m_instret = m_instret + 64'd1;
         if (t[1:0] != 2'b00) begin
            m_trap = 1'b1; m_trap_pc = t; m_state = 2;
         end else begin
            m_pc = t;
         end
      end
      e.pc = m_pc; e.instret = m_instret; e.trap = m_trap; e.trap_pc = m_trap_pc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("pc", {32'd0, pc}, {32'd0, got.pc});
      chk("instret", instret, got.instret);
      chk("trap", {63'd0, trap}, {63'd0, got.trap});
      chk("trap_pc", {32'd0, trap_pc}, {32'd0, got.trap_pc});
   endtask

   initial begin
      // reset overrides stall
      step(1'b1, 2'b01, 32'h0, 32'h55, 1'b1);
      chk("reset_pc", {32'd0, pc}, 64'h0);
      chk("reset_instret", instret, 64'h0);

      // boot cycle, then sequential fetch
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      chk("boot_pc", {32'd0, pc}, 64'h0);
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      chk("seq_pc8", {32'd0, pc}, 64'h8);
      chk("seq_instret2", instret, 64'd2);

      // jalr clears bit 0, branch with negative offset
      step(1'b0, 2'b01, 32'h0, 32'h101, 1'b0);
      chk("jalr_100", {32'd0, pc}, 64'h100);
      step(1'b0, 2'b10, 32'hFFFF_FFF0, 32'h0, 1'b0);
      chk("branch_f0", {32'd0, pc}, 64'hF0);
      step(1'b0, 2'b01, 32'h0, 32'h205, 1'b0);
      chk("jalr_204", {32'd0, pc}, 64'h204);

      // hold idiom still retires
      step(1'b0, 2'b11, 32'h0, 32'h0, 1'b0);
      chk("hold_pc", {32'd0, pc}, 64'h204);
      chk("hold_instret", instret, 64'd6);

      // stall ignores pcsrc/imm/alu_result
      for (int i = 0; i < 4; i++)
         step(1'b0, 2'(i), $urandom, $urandom, 1'b1);
      chk("stall_pc", {32'd0, pc}, 64'h204);
      chk("stall_instret", instret, 64'd6);
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      chk("release_pc", {32'd0, pc}, 64'h208);

      // misaligned branch target traps and freezes
      step(1'b0, 2'b01, 32'h0, 32'h40, 1'b0);
      step(1'b0, 2'b10, 32'h6, 32'h0, 1'b0);
      chk("trap_set", {63'd0, trap}, 64'd1);
      chk("trap_pc46", {32'd0, trap_pc}, 64'h46);
      chk("trap_pc_hold", {32'd0, pc}, 64'h40);
      chk("trap_instret", instret, 64'd9);
      for (int i = 0; i < 10; i++)
         step(1'b0, 2'($urandom), $urandom, $urandom, 1'($urandom));

      // reset out of trap while stalled
      step(1'b1, 2'b10, 32'h0, 32'h0, 1'b1);
      chk("trap_cleared", {63'd0, trap}, 64'd0);
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      chk("refetch_pc4", {32'd0, pc}, 64'h4);

      // pc and instret wrap
      step(1'b0, 2'b01, 32'h0, 32'hFFFF_FFFD, 1'b0);
      chk("top_pc", {32'd0, pc}, 64'hFFFF_FFFC);
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      chk("wrap_pc", {32'd0, pc}, 64'h0);
      chk("wrap_instret", instret, 64'h0);
      chk("wrap_no_trap", {63'd0, trap}, 64'd0);

      // jalr to an address with bit 1 set is misaligned
      step(1'b0, 2'b01, 32'h0, 32'h203, 1'b0);
      chk("jalr_trap", {63'd0, trap}, 64'd1);
      chk("jalr_trap_pc", {32'd0, trap_pc}, 64'h202);
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
